// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS decode definitions (ALU operation encoding,
//                opcode and funct constants) used by decode and execute.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_MULT = 4'd6,
        ALU_LUI  = 4'd7
    } alu_op_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_SLT    = 6'h2A;
    localparam logic [5:0] FN_MULT   = 6'h18;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : NREGS x XLEN register file, two combinational read ports,
//                one synchronous write port, write-through bypass. Register 0
//                is hardwired to zero.
//  Ports       : clk_i, rst_ni (async, active-low), ra_i/rb_i read addresses,
//                ra_data_o/rb_data_o read data, we_i/wa_i/wd_i write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   ra_i,
    input  logic [AW-1:0]   rb_i,
    output logic [XLEN-1:0] ra_data_o,
    output logic [XLEN-1:0] rb_data_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] r_mem_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            r_mem_q[wa_i] <= wd_i;
        end
    end

    // A write landing this cycle is forwarded so the reader never sees the
    // stale value; address 0 short-circuits to zero before the bypass check.
    always_comb begin
        if (ra_i == '0) begin
            ra_data_o = '0;
        end else if (we_i && (wa_i == ra_i)) begin
            ra_data_o = wd_i;
        end else begin
            ra_data_o = r_mem_q[ra_i];
        end
    end

    always_comb begin
        if (rb_i == '0) begin
            rb_data_o = '0;
        end else if (we_i && (wa_i == rb_i)) begin
            rb_data_o = wd_i;
        end else begin
            rb_data_o = r_mem_q[rb_i];
        end
    end

endmodule : regfile_2r1w
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : MIPS instruction decode / register read stage with an ID/EX
//                pipeline register. Supports stall (hold) and flush (bubble).
//  Ports       : clk, reset (async, active-low); in_valid/instr/in_ready
//                instruction input; stall/flush hazard control; wb_en/
//                wb_addr/wb_data register writeback; ex_valid/op1/op2/alu_op/
//                dest_reg/reg_write/illegal ID/EX outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            in_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [3:0]      alu_op,
    output logic [AW-1:0]   dest_reg,
    output logic            reg_write,
    output logic            illegal
);

    logic [5:0]      w_opcode;
    logic [5:0]      w_funct;
    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [AW-1:0]   w_rd;
    logic [15:0]     w_imm;
    logic [XLEN-1:0] w_rs_val;
    logic [XLEN-1:0] w_rt_val;

    logic [XLEN-1:0] w_op1_d;
    logic [XLEN-1:0] w_op2_d;
    alu_op_t         w_alu_op_d;
    logic [AW-1:0]   w_dest_d;
    logic            w_reg_write_d;
    logic            w_illegal_d;

    logic            r_ex_valid_q;
    logic [XLEN-1:0] r_op1_q;
    logic [XLEN-1:0] r_op2_q;
    alu_op_t         r_alu_op_q;
    logic [AW-1:0]   r_dest_q;
    logic            r_reg_write_q;
    logic            r_illegal_q;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_rs     = AW'(instr[25:21]);
    assign w_rt     = AW'(instr[20:16]);
    assign w_rd     = AW'(instr[15:11]);
    assign w_imm    = instr[15:0];

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i     (clk),
        .rst_ni    (reset),
        .ra_i      (w_rs),
        .rb_i      (w_rt),
        .ra_data_o (w_rs_val),
        .rb_data_o (w_rt_val),
        .we_i      (wb_en),
        .wa_i      (wb_addr),
        .wd_i      (wb_data)
    );

    always_comb begin
        w_op1_d       = w_rs_val;
        w_op2_d       = w_rt_val;
        w_alu_op_d    = ALU_NOP;
        w_dest_d      = '0;
        w_reg_write_d = 1'b0;
        w_illegal_d   = 1'b0;
        unique case (w_opcode)
            OPC_RTYPE: begin
                w_dest_d      = w_rd;
                w_reg_write_d = 1'b1;
                unique case (w_funct)
                    FN_ADD:  w_alu_op_d = ALU_ADD;
                    FN_SUB:  w_alu_op_d = ALU_SUB;
                    FN_AND:  w_alu_op_d = ALU_AND;
                    FN_OR:   w_alu_op_d = ALU_OR;
                    FN_SLT:  w_alu_op_d = ALU_SLT;
                    // Product is 64 bits wide; execute owns HI/LO, so no GPR write.
                    FN_MULT: begin
                        w_alu_op_d    = ALU_MULT;
                        w_dest_d      = '0;
                        w_reg_write_d = 1'b0;
                    end
                    default: begin
                        w_dest_d      = '0;
                        w_reg_write_d = 1'b0;
                        w_illegal_d   = 1'b1;
                    end
                endcase
            end
            OPC_ADDI: begin
                w_op2_d       = XLEN'($signed(w_imm));
                w_alu_op_d    = ALU_ADD;
                w_dest_d      = w_rt;
                w_reg_write_d = 1'b1;
            end
            OPC_ANDI: begin
                w_op2_d       = XLEN'(w_imm);
                w_alu_op_d    = ALU_AND;
                w_dest_d      = w_rt;
                w_reg_write_d = 1'b1;
            end
            OPC_ORI: begin
                w_op2_d       = XLEN'(w_imm);
                w_alu_op_d    = ALU_OR;
                w_dest_d      = w_rt;
                w_reg_write_d = 1'b1;
            end
            OPC_LUI: begin
                w_op1_d       = '0;
                w_op2_d       = XLEN'({w_imm, 16'h0000});
                w_alu_op_d    = ALU_LUI;
                w_dest_d      = w_rt;
                w_reg_write_d = 1'b1;
            end
            default: begin
                w_illegal_d   = 1'b1;
            end
        endcase
        // Writes to r0 are architecturally discarded, so never request them.
        if (w_dest_d == '0) begin
            w_reg_write_d = 1'b0;
        end
    end

    // ID/EX register; priority reset > flush > stall > load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex_valid_q  <= 1'b0;
            r_op1_q       <= '0;
            r_op2_q       <= '0;
            r_alu_op_q    <= ALU_NOP;
            r_dest_q      <= '0;
            r_reg_write_q <= 1'b0;
            r_illegal_q   <= 1'b0;
        end else if (flush) begin
            r_ex_valid_q  <= 1'b0;
            r_alu_op_q    <= ALU_NOP;
            r_reg_write_q <= 1'b0;
            r_illegal_q   <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                r_ex_valid_q  <= 1'b1;
                r_op1_q       <= w_op1_d;
                r_op2_q       <= w_op2_d;
                r_alu_op_q    <= w_alu_op_d;
                r_dest_q      <= w_dest_d;
                r_reg_write_q <= w_reg_write_d;
                r_illegal_q   <= w_illegal_d;
            end else begin
                r_ex_valid_q  <= 1'b0;
            end
        end
    end

    assign in_ready  = !stall;
    assign ex_valid  = r_ex_valid_q;
    assign op1       = r_op1_q;
    assign op2       = r_op2_q;
    assign alu_op    = r_alu_op_q;
    assign dest_reg  = r_dest_q;
    assign reg_write = r_reg_write_q;
    assign illegal   = r_illegal_q;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        in_ready;
    logic        ex_valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_op;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADD_3_1_2 = 32'h0022_1820;
    localparam logic [31:0] I_ADD_3_0_0 = 32'h0000_1820;
    localparam logic [31:0] I_ADD_0_1_2 = 32'h0022_0020;
    localparam logic [31:0] I_ADDI_4    = 32'h2004_FFFF;
    localparam logic [31:0] I_ORI_4     = 32'h3404_FFFF;
    localparam logic [31:0] I_LUI_4     = 32'h3C24_1234;  // rs=1 must be ignored
    localparam logic [31:0] I_MULT_1_2  = 32'h0022_0018;
    localparam logic [31:0] I_BAD_OPC   = 32'hFC00_0000;

    decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .instr     (instr),
        .stall     (stall),
        .flush     (flush),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .in_ready  (in_ready),
        .ex_valid  (ex_valid),
        .op1       (op1),
        .op2       (op2),
        .alu_op    (alu_op),
        .dest_reg  (dest_reg),
        .reg_write (reg_write),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [3:0] op,
                          input logic [4:0] d, input logic rw, input logic ill);
        chk({tag, ".ex_valid"},  32'(ex_valid),  32'(v));
        chk({tag, ".alu_op"},    32'(alu_op),    32'(op));
        chk({tag, ".dest_reg"},  32'(dest_reg),  32'(d));
        chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
        chk({tag, ".illegal"},   32'(illegal),   32'(ill));
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #3;
        chk("por.op1", op1, 32'h0);
        chk("por.op2", op2, 32'h0);
        chk_ex("por", 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
        chk("por.in_ready", 32'(in_ready), 32'h1);
        reset = 1'b1;

        // Fill r1=5, r2=7 while no instruction is offered
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        tick();
        chk("bubble.ex_valid", 32'(ex_valid), 32'h0);
        wb_addr = 5'd2; wb_data = 32'd7;
        tick();
        wb_en = 1'b0;

        in_valid = 1'b1; instr = I_ADD_3_1_2;
        tick();
        chk("add.op1", op1, 32'd5);
        chk("add.op2", op2, 32'd7);
        chk_ex("add", 1'b1, 4'd1, 5'd3, 1'b1, 1'b0);

        // Same-cycle writeback to rs must be forwarded
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h10;
        tick();
        wb_en = 1'b0;
        chk("byp.op1", op1, 32'h10);
        chk("byp.op2", op2, 32'd7);

        instr = I_ADDI_4;
        tick();
        chk("addi.op1", op1, 32'h0);
        chk("addi.op2", op2, 32'hFFFF_FFFF);
        chk_ex("addi", 1'b1, 4'd1, 5'd4, 1'b1, 1'b0);

        instr = I_ORI_4;
        tick();
        chk("ori.op2", op2, 32'h0000_FFFF);
        chk("ori.alu_op", 32'(alu_op), 32'd4);

        instr = I_LUI_4;
        tick();
        chk("lui.op1", op1, 32'h0);
        chk("lui.op2", op2, 32'h1234_0000);
        chk_ex("lui", 1'b1, 4'd7, 5'd4, 1'b1, 1'b0);

        // Stall three cycles with a new ADD pending; r2 is rewritten meanwhile
        instr = I_ADD_3_1_2; stall = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd9;
        #1;
        chk("stall.in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_en = 1'b0;
            chk("stall.op2", op2, 32'h1234_0000);
            chk("stall.op1", op1, 32'h0);
            chk_ex("stall", 1'b1, 4'd7, 5'd4, 1'b1, 1'b0);
            chk("stall.in_ready2", 32'(in_ready), 32'h0);
        end
        stall = 1'b0;
        tick();
        chk("post_stall.op1", op1, 32'h10);
        chk("post_stall.op2", op2, 32'd9);
        chk_ex("post_stall", 1'b1, 4'd1, 5'd3, 1'b1, 1'b0);

        // Flush alone keeps in_ready high; flush with stall still bubbles
        flush = 1'b1;
        #1;
        chk("flush.in_ready", 32'(in_ready), 32'h1);
        stall = 1'b1;
        #1;
        chk("flush_stall.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("flush.ex_valid", 32'(ex_valid), 32'h0);
        chk("flush.reg_write", 32'(reg_write), 32'h0);
        chk("flush.alu_op", 32'(alu_op), 32'h0);
        chk("flush.illegal", 32'(illegal), 32'h0);
        flush = 1'b0; stall = 1'b0;

        instr = I_MULT_1_2;
        tick();
        chk("mult.op1", op1, 32'h10);
        chk("mult.op2", op2, 32'd9);
        chk_ex("mult", 1'b1, 4'd6, 5'd0, 1'b0, 1'b0);

        instr = I_BAD_OPC;
        tick();
        chk_ex("illegal", 1'b1, 4'd0, 5'd0, 1'b0, 1'b1);

        // r0 write attempt, both bypass-cycle and afterwards
        instr = I_ADD_3_0_0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        tick();
        wb_en = 1'b0;
        chk("r0_byp.op1", op1, 32'h0);
        chk("r0_byp.op2", op2, 32'h0);
        tick();
        chk("r0.op1", op1, 32'h0);
        chk("r0.op2", op2, 32'h0);

        instr = I_ADD_0_1_2;
        tick();
        chk_ex("add_rd0", 1'b1, 4'd1, 5'd0, 1'b0, 1'b0);

        in_valid = 1'b0;
        tick();
        chk("idle.ex_valid", 32'(ex_valid), 32'h0);

        // Load something, then assert reset between edges
        in_valid = 1'b1; instr = I_ADD_3_1_2;
        tick();
        chk("pre_rst.ex_valid", 32'(ex_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst.op1", op1, 32'h0);
        chk("rst.op2", op2, 32'h0);
        chk_ex("rst", 1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
        tick();
        #2;
        reset = 1'b1;
        tick();
        chk("after_rst.op1", op1, 32'h0);
        chk("after_rst.op2", op2, 32'h0);
        chk_ex("after_rst", 1'b1, 4'd1, 5'd3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
